// File: rtl/scene_timing_pkg.sv
// Shared 640x480@60 scene timing constants.
// Used by scene_timing_gen and by the overlay renderers that consume its outputs.
// Contents: per-axis active/porch/sync lengths, axis totals, default sync levels,
// and a helper that maps "sync active" to a pin level for a given polarity.
package scene_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Default sync polarity is active-low.
  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = 1'b1;

  // Pin level for a sync signal: pol = 0 means active-low.
  function automatic logic sync_level(input logic active, input int pol);
    return (pol != 0) ? active : ~active;
  endfunction

endpackage

// File: rtl/scene_timing_gen_axis.sv
// raster_axis_counter: one raster axis (horizontal or vertical).
// Holds the axis counter (0..TOTAL-1, reset to TOTAL-1) and exposes the value it
// will take on the next edge, so the parent can register outputs that describe
// the counter in the same cycle the counter takes that value.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           advance the counter on this edge
//   cnt_next     counter value after the next edge
//   wrap         the next edge takes the counter from TOTAL-1 back to 0
//   active_next  cnt_next lies in the active region
//   sync_next    cnt_next lies in the sync pulse region
module raster_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CW     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt_next,
  output logic          wrap,
  output logic          active_next,
  output logic          sync_next
);

  localparam int            TOTAL    = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_BEG = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] cnt;

  always_comb begin
    wrap = en && (cnt == LAST);
    if (!en)
      cnt_next = cnt;
    else if (cnt == LAST)
      cnt_next = '0;
    else
      cnt_next = cnt + CW'(1);
    active_next = (cnt_next < ACT_END);
    sync_next   = (cnt_next >= SYNC_BEG) && (cnt_next < SYNC_END);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= LAST;
    else
      cnt <= cnt_next;
  end

endmodule

// File: rtl/scene_timing_gen.sv
// scene_timing_gen: raster timing source for the scene pixel interface.
// Generates 640x480@60 sync/de, pixel coordinates, a 16-bit frame counter and an
// 8-bit day/night fade level. Every output is registered and describes the
// counter position held in the same cycle (zero latency to the renderers).
// Ports:
//   clk_pix        pixel clock
//   rst            asynchronous reset, active-high
//   fade_hold      1 = freeze fade prescaler and fade_level
//   fade_load      strobe: load fade_load_val into fade_level, clear prescaler
//   fade_load_val  value for fade_load
//   hsync, vsync   sync outputs, level per SYNC_POL
//   de             visible region
//   pixel_x/y      coordinate in the visible region, all-ones outside it
//   line_start     first cycle of each line
//   frame_start    first cycle of each frame
//   frame_count    frame index, wraps FFFF->0000
//   fade_level     sawtooth day/night phase
module scene_timing_gen
  import scene_timing_pkg::*;
#(
  parameter int         H_ACTIVE  = VGA_H_ACTIVE,
  parameter int         H_FP      = VGA_H_FP,
  parameter int         H_SYNC    = VGA_H_SYNC,
  parameter int         H_BP      = VGA_H_BP,
  parameter int         V_ACTIVE  = VGA_V_ACTIVE,
  parameter int         V_FP      = VGA_V_FP,
  parameter int         V_SYNC    = VGA_V_SYNC,
  parameter int         V_BP      = VGA_V_BP,
  parameter int         XW        = 10,
  parameter int         YW        = 9,
  parameter int         VCW       = 10,
  parameter int         SYNC_POL  = 0,
  parameter int         FADE_DIV  = 2,
  parameter logic [7:0] FADE_INIT = 8'd0
) (
  input  logic          clk_pix,
  input  logic          rst,
  input  logic          fade_hold,
  input  logic          fade_load,
  input  logic [7:0]    fade_load_val,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_count,
  output logic [7:0]    fade_level
);

  localparam logic SYNC_IDL = sync_level(1'b0, SYNC_POL);

  logic [XW-1:0]       h_next;
  logic [VCW-1:0]      v_next;
  logic                h_wrap, v_wrap;
  logic                h_active_next, v_active_next;
  logic                h_sync_next, v_sync_next;
  logic                frame_wrap;
  logic [FADE_DIV-1:0] prescaler;
  logic                unused_v_msb;

  raster_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CW     (XW)
  ) u_h_axis (
    .clk         (clk_pix),
    .rst         (rst),
    .en          (1'b1),
    .cnt_next    (h_next),
    .wrap        (h_wrap),
    .active_next (h_active_next),
    .sync_next   (h_sync_next)
  );

  raster_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CW     (VCW)
  ) u_v_axis (
    .clk         (clk_pix),
    .rst         (rst),
    .en          (h_wrap),
    .cnt_next    (v_next),
    .wrap        (v_wrap),
    .active_next (v_active_next),
    .sync_next   (v_sync_next)
  );

  // v only advances on h wrap, so a v wrap is already a full frame wrap.
  assign frame_wrap   = v_wrap;
  // Visible lines fit in YW bits; the counter's upper bits only matter in blanking.
  assign unused_v_msb = ^v_next[VCW-1:YW];

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      hsync       <= SYNC_IDL;
      vsync       <= SYNC_IDL;
      de          <= 1'b0;
      pixel_x     <= '1;
      pixel_y     <= '1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '1;
      fade_level  <= FADE_INIT;
      prescaler   <= '0;
    end else begin
      hsync       <= sync_level(h_sync_next, SYNC_POL);
      vsync       <= sync_level(v_sync_next, SYNC_POL);
      de          <= h_active_next && v_active_next;
      pixel_x     <= h_active_next ? h_next : '1;
      pixel_y     <= v_active_next ? v_next[YW-1:0] : '1;
      line_start  <= h_wrap;
      frame_start <= frame_wrap;
      if (frame_wrap)
        frame_count <= frame_count + 16'd1;
      // A load wins over both a coincident step and fade_hold.
      if (fade_load) begin
        fade_level <= fade_load_val;
        prescaler  <= '0;
      end else if (frame_wrap && !fade_hold) begin
        if (prescaler == '1) begin
          prescaler  <= '0;
          fade_level <= fade_level + 8'd1;
        end else begin
          prescaler <= prescaler + FADE_DIV'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_scene_timing_gen.sv
// Bench for scene_timing_gen: a compressed-timing instance (c_*) exercised with
// directed and random fade/reset stimulus, and a default 640x480 instance (s_*)
// checked over its first lines. Expected outputs come from a position-based
// model: edge index since reset -> (h, v) by division/modulo.
module tb_scene_timing_gen;

  typedef struct packed {
    int ha, hf, hs, hb, va, vf, vs, vb, fdiv, finit;
  } tim_t;

  typedef struct packed {
    int hs, vs, de, px, py, ls, fs, fc, fl;
  } out_t;

  localparam int CFL = 25 * 17;  // compressed frame length in cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       fade_hold, fade_load;
  logic [7:0] fade_load_val;

  logic       c_hsync, c_vsync, c_de, c_ls, c_fs;
  logic [9:0] c_px;
  logic [8:0] c_py;
  logic [15:0] c_fc;
  logic [7:0] c_fl;

  logic       s_hsync, s_vsync, s_de, s_ls, s_fs;
  logic [9:0] s_px;
  logic [8:0] s_py;
  logic [15:0] s_fc;
  logic [7:0] s_fl;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit check_en = 1'b0;

  int mk[2];
  int mfc[2];
  int mpre[2];
  int mfade[2];

  always #5 clk = ~clk;

  scene_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .XW(10), .YW(9), .VCW(10), .SYNC_POL(0), .FADE_DIV(2), .FADE_INIT(8'd0)
  ) dut (
    .clk_pix(clk), .rst(rst), .fade_hold(fade_hold), .fade_load(fade_load),
    .fade_load_val(fade_load_val), .hsync(c_hsync), .vsync(c_vsync), .de(c_de),
    .pixel_x(c_px), .pixel_y(c_py), .line_start(c_ls), .frame_start(c_fs),
    .frame_count(c_fc), .fade_level(c_fl)
  );

  scene_timing_gen dut_std (
    .clk_pix(clk), .rst(rst), .fade_hold(1'b0), .fade_load(1'b0),
    .fade_load_val(8'd0), .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
    .pixel_x(s_px), .pixel_y(s_py), .line_start(s_ls), .frame_start(s_fs),
    .frame_count(s_fc), .fade_level(s_fl)
  );

  function automatic tim_t tim(input int i);
    if (i == 0) return '{16, 2, 4, 3, 10, 2, 2, 3, 2, 0};
    return '{640, 16, 96, 48, 480, 10, 2, 33, 2, 0};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference model: counts edges since reset; fade rules applied at frame wraps.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      tim_t t;
      int   nk, fl, pos;
      logic ld, hd;
      logic [7:0] lv;
      t = tim(i);
      if (rst) begin
        mk[i]    <= -1;
        mfc[i]   <= 65535;
        mpre[i]  <= 0;
        mfade[i] <= t.finit;
      end else begin
        ld  = (i == 0) ? fade_load : 1'b0;
        hd  = (i == 0) ? fade_hold : 1'b0;
        lv  = (i == 0) ? fade_load_val : 8'd0;
        fl  = (t.ha + t.hf + t.hs + t.hb) * (t.va + t.vf + t.vs + t.vb);
        nk  = mk[i] + 1;
        pos = nk % fl;
        mk[i] <= nk;
        if (pos == 0) mfc[i] <= (mfc[i] + 1) % 65536;
        if (ld) begin
          mfade[i] <= lv;
          mpre[i]  <= 0;
        end else if (pos == 0 && !hd) begin
          if (mpre[i] == (1 << t.fdiv) - 1) begin
            mpre[i]  <= 0;
            mfade[i] <= (mfade[i] + 1) % 256;
          end else begin
            mpre[i] <= mpre[i] + 1;
          end
        end
      end
    end
  end

  function automatic out_t expect_out(input int i);
    tim_t t;
    out_t o;
    int ht, vt, pos, h, v;
    t  = tim(i);
    ht = t.ha + t.hf + t.hs + t.hb;
    vt = t.va + t.vf + t.vs + t.vb;
    if (mk[i] < 0) begin
      o.hs = 1; o.vs = 1; o.de = 0; o.px = 1023; o.py = 511; o.ls = 0; o.fs = 0;
    end else begin
      pos  = mk[i] % (ht * vt);
      h    = pos % ht;
      v    = pos / ht;
      o.hs = (h >= t.ha + t.hf && h < t.ha + t.hf + t.hs) ? 0 : 1;
      o.vs = (v >= t.va + t.vf && v < t.va + t.vf + t.vs) ? 0 : 1;
      o.de = (h < t.ha && v < t.va) ? 1 : 0;
      o.px = (h < t.ha) ? h : 1023;
      o.py = (v < t.va) ? v : 511;
      o.ls = (h == 0) ? 1 : 0;
      o.fs = (pos == 0) ? 1 : 0;
    end
    o.fc = mfc[i];
    o.fl = mfade[i];
    return o;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      out_t e;
      e = expect_out(0);
      chk("c_hsync", int'(c_hsync), e.hs);
      chk("c_vsync", int'(c_vsync), e.vs);
      chk("c_de", int'(c_de), e.de);
      chk("c_pixel_x", int'(c_px), e.px);
      chk("c_pixel_y", int'(c_py), e.py);
      chk("c_line_start", int'(c_ls), e.ls);
      chk("c_frame_start", int'(c_fs), e.fs);
      chk("c_frame_count", int'(c_fc), e.fc);
      chk("c_fade_level", int'(c_fl), e.fl);
      e = expect_out(1);
      chk("s_hsync", int'(s_hsync), e.hs);
      chk("s_vsync", int'(s_vsync), e.vs);
      chk("s_de", int'(s_de), e.de);
      chk("s_pixel_x", int'(s_px), e.px);
      chk("s_pixel_y", int'(s_py), e.py);
      chk("s_line_start", int'(s_ls), e.ls);
      chk("s_frame_start", int'(s_fs), e.fs);
      chk("s_frame_count", int'(s_fc), e.fc);
      chk("s_fade_level", int'(s_fl), e.fl);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_c_px"}, int'(c_px), 1023);
    chk({tag, "_c_py"}, int'(c_py), 511);
    chk({tag, "_c_hsync"}, int'(c_hsync), 1);
    chk({tag, "_c_vsync"}, int'(c_vsync), 1);
    chk({tag, "_c_de"}, int'(c_de), 0);
    chk({tag, "_c_fs"}, int'(c_fs), 0);
    chk({tag, "_c_ls"}, int'(c_ls), 0);
    chk({tag, "_c_fc"}, int'(c_fc), 65535);
    chk({tag, "_c_fl"}, int'(c_fl), 0);
    chk({tag, "_s_px"}, int'(s_px), 1023);
    chk({tag, "_s_fc"}, int'(s_fc), 65535);
  endtask

  task automatic chk_first_edge(input string tag);
    chk({tag, "_c_px0"}, int'(c_px), 0);
    chk({tag, "_c_py0"}, int'(c_py), 0);
    chk({tag, "_c_de0"}, int'(c_de), 1);
    chk({tag, "_c_fs0"}, int'(c_fs), 1);
    chk({tag, "_c_ls0"}, int'(c_ls), 1);
    chk({tag, "_c_fc0"}, int'(c_fc), 0);
    chk({tag, "_c_fl0"}, int'(c_fl), 0);
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    fade_hold = 1'b0;
    fade_load = 1'b0;
    fade_load_val = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_en = 1'b1;
    chk_reset_vals("rst");

    // Release and walk the first frames with literal checkpoints.
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      case (k)
        0: begin
          chk_first_edge("start");
          chk("s_px_k0", int'(s_px), 0);
          chk("s_fs_k0", int'(s_fs), 1);
        end
        1: begin
          chk("c_px_k1", int'(c_px), 1);
          chk("s_px_k1", int'(s_px), 1);
          chk("s_ls_k1", int'(s_ls), 0);
        end
        17:   chk("c_hsync_h17", int'(c_hsync), 1);
        18:   chk("c_hsync_h18", int'(c_hsync), 0);
        21:   chk("c_hsync_h21", int'(c_hsync), 0);
        22:   chk("c_hsync_h22", int'(c_hsync), 1);
        250: begin
          chk("c_py_line10", int'(c_py), 511);
          chk("c_de_line10", int'(c_de), 0);
        end
        299:  chk("c_vsync_l11", int'(c_vsync), 1);
        300:  chk("c_vsync_l12", int'(c_vsync), 0);
        349:  chk("c_vsync_l13", int'(c_vsync), 0);
        350:  chk("c_vsync_l14", int'(c_vsync), 1);
        425: begin
          chk("c_fc_frame1", int'(c_fc), 1);
          chk("c_fs_frame1", int'(c_fs), 1);
        end
        639: begin
          chk("s_de_h639", int'(s_de), 1);
          chk("s_px_h639", int'(s_px), 639);
        end
        640: begin
          chk("s_de_h640", int'(s_de), 0);
          chk("s_px_h640", int'(s_px), 1023);
        end
        655:  chk("s_hsync_h655", int'(s_hsync), 1);
        656:  chk("s_hsync_h656", int'(s_hsync), 0);
        751:  chk("s_hsync_h751", int'(s_hsync), 0);
        752:  chk("s_hsync_h752", int'(s_hsync), 1);
        800: begin
          chk("s_ls_line1", int'(s_ls), 1);
          chk("s_px_line1", int'(s_px), 0);
          chk("s_py_line1", int'(s_py), 1);
        end
        1274: chk("c_fl_wrap3", int'(c_fl), 0);
        1275: chk("c_fl_wrap4", int'(c_fl), 1);
        2974: chk("c_fl_wrap7", int'(c_fl), 1);
        2975: chk("c_fl_wrap8", int'(c_fl), 2);
        default: ;
      endcase
    end

    // Load 255 mid-frame; the fourth wrap afterwards rolls it to 0.
    @(negedge clk);
    fade_load = 1'b1;
    fade_load_val = 8'd255;
    @(negedge clk);
    fade_load = 1'b0;
    repeat (1275) @(posedge clk);
    #1 chk("c_fl_load255_3wraps", int'(c_fl), 255);
    repeat (425) @(posedge clk);
    #1 chk("c_fl_load255_4wraps", int'(c_fl), 0);

    // Hold for 8 frames: level frozen.
    @(negedge clk);
    fade_hold = 1'b1;
    repeat (8 * CFL) @(posedge clk);
    #1 chk("c_fl_hold8", int'(c_fl), 0);
    @(negedge clk);
    fade_hold = 1'b0;

    // Load 200 with hold=1 on the edge where a step is due.
    found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge clk);
      if (mpre[0] == 3 && ((mk[0] + 1) % CFL) == 0) found = 1'b1;
    end
    chk("align_due_step", int'(found), 1);
    fade_hold = 1'b1;
    fade_load = 1'b1;
    fade_load_val = 8'd200;
    @(posedge clk);
    #1 chk("c_fl_load200", int'(c_fl), 200);
    @(negedge clk);
    fade_hold = 1'b0;
    fade_load = 1'b0;
    repeat (1699) @(posedge clk);
    #1 chk("c_fl_200_before", int'(c_fl), 200);
    @(posedge clk);
    #1 chk("c_fl_200_step", int'(c_fl), 201);

    // Asynchronous reset mid-frame (h=12, v=5).
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      @(negedge clk);
      if (((mk[0] + 1) % CFL) == 5 * 25 + 12) found = 1'b1;
    end
    chk("align_midframe", int'(found), 1);
    fade_load = 1'b1;
    fade_load_val = 8'd77;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_vals("async");
    fade_load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk_first_edge("rerelease");
    @(posedge clk);
    #1 chk("c_px_rerelease_k1", int'(c_px), 1);

    // Random fade traffic and occasional resets.
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      fade_load = ($urandom_range(0, 299) == 0);
      fade_load_val = 8'($urandom);
      if ($urandom_range(0, 499) == 0) fade_hold = ~fade_hold;
      if (rst) rst = 1'b0;
      else rst = ($urandom_range(0, 6999) == 0);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
